// File: rtl/iz_pkg.sv
// Shared types and fixed-point constants for the Izhikevich neuron array.
// Voltages are Q(DATA_W-IZ_FRAC).IZ_FRAC, so 1 mV corresponds to 64 LSBs.
package iz_pkg;

    localparam int IZ_FRAC = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_UPDATE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SEL_A = 2'd0,
        SEL_B = 2'd1,
        SEL_C = 2'd2,
        SEL_D = 2'd3
    } cfg_sel_e;

    localparam int V_REST    = -70 * (1 << IZ_FRAC);
    localparam int V_THRESH  = 30 * (1 << IZ_FRAC);
    localparam int CONST_140 = 140 * (1 << IZ_FRAC);

    // Regular-spiking defaults: a=0.02, b=0.2, c=-65 mV, d=8.
    localparam int A_DEF = 1;
    localparam int B_DEF = 13;
    localparam int C_DEF = -65 * (1 << IZ_FRAC);
    localparam int D_DEF = 8 * (1 << IZ_FRAC);

endpackage

// File: rtl/iz_neuron_update.sv
// Combinational Izhikevich step: (v, u, a, b, c, d, stim) -> (v', u', spike, membrane).
// All arithmetic runs in a wide signed domain and saturates back to DATA_W.
module iz_neuron_update
    import iz_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = IZ_FRAC,
    parameter int STIM_W    = 8,
    parameter int DT_SHIFT  = 0
) (
    input  logic signed [DATA_W-1:0] v_i,
    input  logic signed [DATA_W-1:0] u_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    input  logic signed [DATA_W-1:0] c_i,
    input  logic signed [DATA_W-1:0] d_i,
    input  logic        [STIM_W-1:0] stim_i,
    output logic signed [DATA_W-1:0] v_o,
    output logic signed [DATA_W-1:0] u_o,
    output logic                     spike_o,
    output logic        [6:0]        membrane_o
);

    localparam int W = 2 * DATA_W + 16;
    typedef logic signed [W-1:0] wide_t;

    localparam wide_t SAT_MAX = wide_t'((longint'(1) <<< (DATA_W - 1)) - 1);
    localparam wide_t SAT_MIN = -SAT_MAX - wide_t'(1);
    localparam wide_t K5      = wide_t'(5);
    localparam wide_t K41     = wide_t'(41);

    function automatic logic signed [DATA_W-1:0] sat(input wide_t x);
        if (x > SAT_MAX) return DATA_W'(SAT_MAX);
        if (x < SAT_MIN) return DATA_W'(SAT_MIN);
        return DATA_W'(x);
    endfunction

    wide_t v_w, u_w, a_w, b_w, d_w, stim_w;
    wide_t sq, dv, bv, du, mem;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        v_o        = c_i;
        u_o        = u_i;
        spike_o    = 1'b0;
        membrane_o = '0;

        v_w    = wide_t'(v_i);
        u_w    = wide_t'(u_i);
        a_w    = wide_t'(a_i);
        b_w    = wide_t'(b_i);
        d_w    = wide_t'(d_i);
        stim_w = wide_t'(stim_i);

        sq  = (v_w * v_w * K41) >>> (10 + FRAC_BITS);
        dv  = sq + K5 * v_w + wide_t'(CONST_140) - u_w + (stim_w <<< FRAC_BITS);
        bv  = (b_w * v_w) >>> FRAC_BITS;
        du  = (a_w * (bv - u_w)) >>> FRAC_BITS;
        mem = (v_w - wide_t'(V_REST)) >>> FRAC_BITS;

        if (v_w >= wide_t'(V_THRESH)) begin
            spike_o = 1'b1;
            v_o     = c_i;
            u_o     = sat(u_w + d_w);
        end else begin
            v_o = sat(v_w + (dv >>> DT_SHIFT));
            u_o = sat(u_w + (du >>> DT_SHIFT));
        end

        if (mem < 0)                 membrane_o = 7'd0;
        else if (mem > wide_t'(127)) membrane_o = 7'd127;
        else                         membrane_o = 7'(mem);
    end

endmodule

// File: rtl/iz_neuron_array.sv
// Time-multiplexed Izhikevich neuron array: per-neuron state/parameter arrays,
// a READ/UPDATE sweep FSM driven by tick, and registered per-neuron samples.
module iz_neuron_array
    import iz_pkg::*;
#(
    parameter int N_NEURONS = 4,
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = IZ_FRAC,
    parameter int STIM_W    = 8,
    parameter int DT_SHIFT  = 0,
    localparam int IDX_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     tick,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic        [IDX_W-1:0]  cfg_addr,
    input  logic        [1:0]        cfg_sel,
    input  logic signed [DATA_W-1:0] cfg_data,
    input  logic                     stim_we,
    input  logic        [IDX_W-1:0]  stim_addr,
    input  logic        [STIM_W-1:0] stim_data,
    output logic                     out_valid,
    output logic        [IDX_W-1:0]  out_id,
    output logic                     out_spike,
    output logic        [6:0]        out_membrane,
    output logic                     sweep_done,
    output logic                     overrun
);

    state_e            state_q, state_d;
    logic  [IDX_W-1:0] idx_q, idx_d;
    logic              last, do_read, do_update, cfg_we, stim_ok;

    logic signed [DATA_W-1:0] v_q [N_NEURONS];
    logic signed [DATA_W-1:0] u_q [N_NEURONS];
    logic signed [DATA_W-1:0] a_q [N_NEURONS];
    logic signed [DATA_W-1:0] b_q [N_NEURONS];
    logic signed [DATA_W-1:0] c_q [N_NEURONS];
    logic signed [DATA_W-1:0] d_q [N_NEURONS];
    logic        [STIM_W-1:0] stim_q [N_NEURONS];

    logic signed [DATA_W-1:0] lv_q, lu_q, la_q, lb_q, lc_q, ld_q;
    logic        [STIM_W-1:0] lstim_q;

    logic signed [DATA_W-1:0] v_n, u_n;
    logic                     spike_n;
    logic        [6:0]        mem_n;

    logic             out_valid_q, out_spike_q, sweep_done_q, overrun_q;
    logic [IDX_W-1:0] out_id_q;
    logic [6:0]       out_membrane_q;

    assign last = (int'(idx_q) == N_NEURONS - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (enable) begin
            case (state_q)
                ST_IDLE: if (tick) begin
                    state_d = ST_READ;
                    idx_d   = '0;
                end
                ST_READ: state_d = ST_UPDATE;
                ST_UPDATE: begin
                    if (last) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_READ;
                        idx_d   = idx_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_ready = (state_q == ST_IDLE) && !reset;
        do_read   = enable && (state_q == ST_READ);
        do_update = enable && (state_q == ST_UPDATE);
        cfg_we    = cfg_valid && cfg_ready && (int'(cfg_addr) < N_NEURONS);
        stim_ok   = stim_we && (int'(stim_addr) < N_NEURONS);
    end

    iz_neuron_update #(
        .DATA_W   (DATA_W),
        .FRAC_BITS(FRAC_BITS),
        .STIM_W   (STIM_W),
        .DT_SHIFT (DT_SHIFT)
    ) u_update (
        .v_i       (lv_q),
        .u_i       (lu_q),
        .a_i       (la_q),
        .b_i       (lb_q),
        .c_i       (lc_q),
        .d_i       (ld_q),
        .stim_i    (lstim_q),
        .v_o       (v_n),
        .u_o       (u_n),
        .spike_o   (spike_n),
        .membrane_o(mem_n)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the arrays are small flop banks whose reset values are part of the
            // neuron model (rest potential, default parameters), so they are reset too.
            for (int i = 0; i < N_NEURONS; i++) begin
                v_q[i]    <= DATA_W'(V_REST);
                u_q[i]    <= '0;
                a_q[i]    <= DATA_W'(A_DEF);
                b_q[i]    <= DATA_W'(B_DEF);
                c_q[i]    <= DATA_W'(C_DEF);
                d_q[i]    <= DATA_W'(D_DEF);
                stim_q[i] <= '0;
            end
            {lv_q, lu_q, la_q, lb_q, lc_q, ld_q} <= '0;
            lstim_q        <= '0;
            out_valid_q    <= 1'b0;
            out_id_q       <= '0;
            out_spike_q    <= 1'b0;
            out_membrane_q <= '0;
            sweep_done_q   <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            out_valid_q  <= do_update;
            sweep_done_q <= do_update && last;

            if (do_read) begin
                lv_q    <= v_q[idx_q];
                lu_q    <= u_q[idx_q];
                la_q    <= a_q[idx_q];
                lb_q    <= b_q[idx_q];
                lc_q    <= c_q[idx_q];
                ld_q    <= d_q[idx_q];
                lstim_q <= stim_q[idx_q];
            end

            if (do_update) begin
                v_q[idx_q]     <= v_n;
                u_q[idx_q]     <= u_n;
                out_id_q       <= idx_q;
                out_spike_q    <= spike_n;
                out_membrane_q <= mem_n;
            end

            if (cfg_we) begin
                case (cfg_sel_e'(cfg_sel))
                    SEL_A:   a_q[cfg_addr] <= cfg_data;
                    SEL_B:   b_q[cfg_addr] <= cfg_data;
                    SEL_C:   c_q[cfg_addr] <= cfg_data;
                    default: d_q[cfg_addr] <= cfg_data;
                endcase
            end

            // A read on this same edge still latches the previous stimulus.
            if (stim_ok) stim_q[stim_addr] <= stim_data;

            if (enable && tick && (state_q != ST_IDLE)) overrun_q <= 1'b1;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_id       = out_id_q;
    assign out_spike    = out_spike_q;
    assign out_membrane = out_membrane_q;
    assign sweep_done   = sweep_done_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_iz_neuron_array.sv
// Scoreboard bench for iz_neuron_array: stimulus pushes expected samples,
// a negedge monitor pops and compares every out_valid strobe.
module tb_iz_neuron_array;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              reset, enable, tick, cfg_valid, stim_we;
    logic [1:0]        cfg_addr, cfg_sel, stim_addr;
    logic signed [15:0] cfg_data;
    logic [7:0]        stim_data;
    logic              cfg_ready, out_valid, out_spike, sweep_done, overrun;
    logic [1:0]        out_id;
    logic [6:0]        out_membrane;

    iz_neuron_array dut (
        .clk(clk), .reset(reset), .enable(enable), .tick(tick),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
        .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .stim_we(stim_we), .stim_addr(stim_addr), .stim_data(stim_data),
        .out_valid(out_valid), .out_id(out_id), .out_spike(out_spike),
        .out_membrane(out_membrane), .sweep_done(sweep_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // cyc equals the number of rising edges seen so far when read at a negedge.
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int     id;
        bit     spk;
        int     mem;
        bit     done;
        longint at;
    } exp_t;

    exp_t sb[$];

    // Reference neuron state, kept in 64-bit integers.
    longint m_v[N], m_u[N], m_a[N], m_b[N], m_c[N], m_d[N], m_stim[N];

    function automatic longint sat16(input longint x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_v[k] = -4480; m_u[k] = 0;
            m_a[k] = 1;     m_b[k] = 13; m_c[k] = -4160; m_d[k] = 512;
            m_stim[k] = 0;
        end
    endtask

    task automatic model_step(input int k, output bit spk, output int mem);
        longint v, u, m, sq, dv, du;
        v = m_v[k];
        u = m_u[k];
        m = (v + 4480) >>> 6;
        mem = (m < 0) ? 0 : (m > 127) ? 127 : int'(m);
        if (v >= 1920) begin
            spk = 1'b1;
            m_v[k] = m_c[k];
            m_u[k] = sat16(u + m_d[k]);
        end else begin
            spk = 1'b0;
            sq = (v * v * 41) >>> 16;
            dv = sq + 5 * v + 8960 - u + m_stim[k] * 64;
            du = (m_a[k] * (((m_b[k] * v) >>> 6) - u)) >>> 6;
            m_v[k] = sat16(v + dv);
            m_u[k] = sat16(u + du);
        end
    endtask

    // Monitor state for scenario-specific properties.
    exp_t mon_e;
    bit   scen2 = 1'b0;
    bit   prev_spk2 = 1'b0;
    int   spikes2 = 0;
    int   last_mem[N];

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: id %0d arrived with nothing expected", out_id);
            end else begin
                mon_e = sb.pop_front();
                check("out_id", out_id, mon_e.id);
                check("out_spike", out_spike, mon_e.spk);
                check("out_membrane", out_membrane, mon_e.mem);
                check("sweep_done", sweep_done, mon_e.done);
                check("strobe_cycle", cyc, mon_e.at);
            end
            last_mem[out_id] = out_membrane;
            if (scen2) begin
                if (out_id != 2'd2) begin
                    check("quiet_neuron_spike", out_spike, 0);
                end else begin
                    if (prev_spk2) check("post_spike_membrane", out_membrane, 5);
                    prev_spk2 = out_spike;
                    if (out_spike) spikes2++;
                end
            end
        end else if (sweep_done === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_without_valid: sweep_done high with out_valid low");
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_stim(input int k, input int val);
        stim_we   = 1'b1;
        stim_addr = 2'(k);
        stim_data = 8'(val);
        @(negedge clk);
        stim_we = 1'b0;
        m_stim[k] = val;
    endtask

    task automatic write_cfg(input int k, input int sel, input int val, output longint acc);
        int waited = 0;
        cfg_valid = 1'b1;
        cfg_addr  = 2'(k);
        cfg_sel   = 2'(sel);
        cfg_data  = 16'(val);
        acc = -1;
        while (cfg_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (cfg_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL cfg_timeout: cfg_ready stayed low for %0d cycles", waited);
            cfg_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        @(negedge clk);
        cfg_valid = 1'b0;
        case (sel)
            0:       m_a[k] = val;
            1:       m_b[k] = val;
            2:       m_c[k] = val;
            default: m_d[k] = val;
        endcase
    endtask

    // Pulses tick for one cycle and pushes the first n_push samples of the sweep.
    // hand=1 pushes the known post-reset values instead of model output.
    task automatic start_sweep(input int n_push, input int delay, input bit hand,
                               output longint e0);
        exp_t e;
        bit   spk;
        int   mem;
        tick = 1'b1;
        e0 = cyc + 1;
        for (int k = 0; k < n_push; k++) begin
            model_step(k, spk, mem);
            e.id   = k;
            e.spk  = hand ? 1'b0 : spk;
            e.mem  = hand ? 0 : mem;
            e.done = (k == N - 1);
            e.at   = e0 + 2 * k + 2 + delay;
            sb.push_back(e);
        end
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic run_sweep(input bit hand);
        longint e0;
        start_sweep(N, 0, hand, e0);
        idle(2 * N + 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint e0, acc;
        reset = 1'b1; enable = 1'b1; tick = 1'b0; cfg_valid = 1'b0; stim_we = 1'b0;
        cfg_addr = '0; cfg_sel = '0; cfg_data = '0; stim_addr = '0; stim_data = '0;
        for (int k = 0; k < N; k++) last_mem[k] = 0;
        model_reset();
        idle(3);

        check("reset_cfg_ready", cfg_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_overrun", overrun, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_cfg_ready", cfg_ready, 1);
        check("post_reset_membrane", out_membrane, 0);
        check("post_reset_sweep_done", sweep_done, 0);

        // First sweep with defaults: every neuron at rest, membrane 0, no spikes.
        run_sweep(1'b1);

        // Enable held low for three cycles inside a sweep delays every strobe by three.
        start_sweep(N, 3, 1'b0, e0);
        enable = 1'b0;
        idle(3);
        enable = 1'b1;
        idle(2 * N + 1);

        // Neuron 2 alone driven with stim 10 across many steps.
        write_stim(2, 10);
        scen2 = 1'b1;
        repeat (150) run_sweep(1'b0);
        scen2 = 1'b0;
        check("neuron2_spiked_twice", (spikes2 >= 2) ? 1 : 0, 1);
        write_stim(2, 0);

        // Neuron 0: a=0, d=0x7FFF, maximal stim, so u must saturate on repeated spikes.
        write_cfg(0, 0, 0, acc);
        write_cfg(0, 3, 32'h7FFF, acc);
        write_stim(0, 255);
        repeat (8) run_sweep(1'b0);

        // Tick arriving mid-sweep only raises overrun.
        check("overrun_before", overrun, 0);
        start_sweep(N, 0, 1'b0, e0);
        idle(2);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        idle(2 * N + 4);
        check("overrun_after", overrun, 1);

        // Config write issued during a sweep stalls until IDLE, then changes c of neuron 3.
        write_stim(3, 255);
        start_sweep(N, 0, 1'b0, e0);
        check("cfg_ready_busy", cfg_ready, 0);
        write_cfg(3, 2, -3200, acc);
        check("cfg_accept_cycle", acc, e0 + 2 * N + 1);
        idle(2);
        run_sweep(1'b0);
        run_sweep(1'b0);
        check("new_c_readback", last_mem[3], 20);

        // Reset while neuron 1 is in UPDATE aborts the sweep and restores everything.
        start_sweep(1, 0, 1'b0, e0);
        idle(3);
        reset = 1'b1;
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_sweep_done", sweep_done, 0);
        check("abort_overrun", overrun, 0);
        check("abort_out_id", out_id, 0);
        check("abort_out_spike", out_spike, 0);
        check("abort_out_membrane", out_membrane, 0);
        check("abort_cfg_ready", cfg_ready, 0);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("abort_cfg_ready_after", cfg_ready, 1);
        run_sweep(1'b1);
        run_sweep(1'b0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
